// File: rtl/switch_pkg.sv
// switch_pkg: constants, header layout and packet generator state type shared with ingress
package switch_pkg;
  localparam int          BLOCK_WORDS  = 8;
  localparam logic [47:0] MAC_BASE     = 48'h02_00_00_00_00_00;
  localparam logic [31:0] PG_LFSR_SEED = 32'hACE1_0001;
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  typedef logic [2:0] pg_state_t;
  localparam pg_state_t PG_IDLE    = 3'd0;
  localparam pg_state_t PG_START   = 3'd1;
  localparam pg_state_t PG_HDR0    = 3'd2;
  localparam pg_state_t PG_HDR1    = 3'd3;
  localparam pg_state_t PG_SEQ     = 3'd4;
  localparam pg_state_t PG_PAYLOAD = 3'd5;
  localparam pg_state_t PG_GAP     = 3'd6;
  // Word 0: length in blocks at [26:21], upper 16 bits of the destination MAC at [15:0]
  function automatic logic [31:0] hdr_w0(input logic [5:0] len, input logic [15:0] dmac_hi);
    return {5'b0, len, 5'b0, dmac_hi};
  endfunction
endpackage

// File: rtl/lfsr32.sv
// lfsr32: 32-bit Galois LFSR payload source
//   clk, reset (async, active-low), en advances one step, load reloads seed (load wins), q current state
module lfsr32
  import switch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (load) q <= seed;
    else if (en) q <= {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : 32'h0);
endmodule

// File: rtl/packet_gen.sv
// packet_gen: job-driven packet source for the packet-gen -> ingress segment interface
//   clk, reset (async, active-low)
//   cfg_valid/cfg_ready job handshake; cfg_dest, cfg_len (blocks), cfg_count, cfg_gap (idle blocks)
//   hold: ingress backpressure, only consulted before a packet starts
//   abort: finish the current packet, then stop the job
//   packet_out/packet_en/new_packet_en: registered word stream; busy = ~cfg_ready
//   sent_count: packets completed in the current job
module packet_gen
  import switch_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = PG_LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_dest,
  input  logic [5:0]  cfg_len,
  input  logic [15:0] cfg_count,
  input  logic [7:0]  cfg_gap,
  input  logic        hold,
  input  logic        abort,
  output logic [31:0] packet_out,
  output logic        packet_en,
  output logic        new_packet_en,
  output logic        busy,
  output logic [15:0] sent_count
);
  pg_state_t   state, next_state;
  logic [1:0]  dest_q;
  logic [5:0]  len_q;
  logic [7:0]  gap_q;
  logic [15:0] remaining, seq;
  logic [8:0]  word_cnt;
  logic [10:0] gap_cnt;
  logic        abort_q;
  logic [31:0] lfsr_q;
  logic [47:0] dmac;
  logic        accept, empty_job, abort_any, last_word;

  assign cfg_ready = state == PG_IDLE;
  assign busy      = ~cfg_ready;
  assign accept    = cfg_valid & cfg_ready;
  assign empty_job = cfg_len == 6'd0 || cfg_count == 16'd0;
  assign abort_any = abort_q | abort;
  assign last_word = state == PG_PAYLOAD && word_cnt == 9'd0;
  assign dmac      = MAC_BASE | {46'b0, dest_q};

  lfsr32 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .en   (state == PG_PAYLOAD),
    .load (accept),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // With no gap the next header follows the last payload word directly so packets stay contiguous;
  // the GAP exit likewise goes straight to HDR0 so the idle time is exactly 8*gap cycles.
  always_comb begin
    next_state = state;
    case (state)
      PG_IDLE:    next_state = accept && !empty_job ? PG_START : PG_IDLE;
      PG_START:   next_state = abort_any ? PG_IDLE : hold ? PG_START : PG_HDR0;
      PG_HDR0:    next_state = PG_HDR1;
      PG_HDR1:    next_state = PG_SEQ;
      PG_SEQ:     next_state = PG_PAYLOAD;
      PG_PAYLOAD: next_state = !last_word ? PG_PAYLOAD :
                               remaining == 16'd1 || abort_any ? PG_IDLE :
                               gap_q != 8'd0 ? PG_GAP : hold ? PG_START : PG_HDR0;
      PG_GAP:     next_state = abort_any ? PG_IDLE : gap_cnt != 11'd0 ? PG_GAP :
                               hold ? PG_START : PG_HDR0;
      default:    next_state = PG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= PG_IDLE;
      dest_q        <= '0;
      len_q         <= '0;
      gap_q         <= '0;
      remaining     <= '0;
      seq           <= '0;
      sent_count    <= '0;
      word_cnt      <= '0;
      gap_cnt       <= '0;
      abort_q       <= 1'b0;
      packet_out    <= '0;
      packet_en     <= 1'b0;
      new_packet_en <= 1'b0;
    end else begin
      state   <= next_state;
      abort_q <= state != PG_IDLE && next_state != PG_IDLE && abort_any;
      if (accept) begin
        dest_q     <= cfg_dest;
        len_q      <= cfg_len;
        gap_q      <= cfg_gap;
        remaining  <= cfg_count;
        seq        <= '0;
        sent_count <= '0;
      end
      // Three header words precede the payload, so payload runs 8*len-3 words (count down to 0)
      if (state == PG_SEQ) word_cnt <= 9'(len_q) * 9'(BLOCK_WORDS) - 9'd4;
      else if (state == PG_PAYLOAD) word_cnt <= word_cnt - 9'd1;
      if (last_word) begin
        remaining  <= remaining - 16'd1;
        seq        <= seq + 16'd1;
        sent_count <= sent_count + 16'd1;
        gap_cnt    <= 11'(gap_q) * 11'(BLOCK_WORDS) - 11'd1;
      end else if (state == PG_GAP) gap_cnt <= gap_cnt - 11'd1;
      packet_en     <= state inside {PG_HDR0, PG_HDR1, PG_SEQ, PG_PAYLOAD};
      new_packet_en <= state == PG_HDR0;
      packet_out    <= state == PG_HDR0    ? hdr_w0(len_q, dmac[47:32]) :
                       state == PG_HDR1    ? dmac[31:0] :
                       state == PG_SEQ     ? {14'b0, dest_q, seq} :
                       state == PG_PAYLOAD ? lfsr_q : 32'h0;
    end
endmodule
